// File: rtl/q_dequant_stream_pkg.sv
// sys_defs: shared fixed-point helpers and the dequantizer control state type
package sys_defs;

    localparam bit ROUNDING = 1'b1;

    function automatic int Q_WIDTH(input int i, input int f);
        return i + f + 1;
    endfunction

    typedef enum logic {WAIT_SCALE, ACTIVE} dq_state_e;

endpackage

// File: rtl/q_dequant_stream_round_sat.sv
// q_round_sat: per-lane fractional alignment with optional round-half-up and saturation
module q_round_sat #(
    parameter int IW  = 24,
    parameter int FI  = 18,
    parameter int OW  = 16,
    parameter int FO  = 8,
    parameter bit RND = 1'b1
) (
    input  logic signed [IW-1:0] in_i,
    output logic        [OW-1:0] out_o
);

    localparam int UP = (FO > FI) ? FO - FI : 0;
    localparam int WW = IW + UP + OW + 2;
    localparam logic signed [WW-1:0] MAXV = {{(WW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = {{(WW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] al;

    assign ext = WW'(in_i);

    generate
        if (FO > FI) begin : g_up
            assign al = ext <<< UP;
        end else if (FO == FI) begin : g_eq
            assign al = ext;
        end else begin : g_dn
            localparam int SH = FI - FO;
            localparam logic signed [WW-1:0] BIAS = RND ? WW'(1) <<< (SH - 1) : '0;
            assign al = (ext + BIAS) >>> SH;
        end
    endgenerate

    // clamp the aligned value to the output code range instead of wrapping
    always_comb out_o = (al > MAXV) ? MAXV[OW-1:0] : (al < MINV) ? MINV[OW-1:0] : al[OW-1:0];

endmodule

// File: rtl/q_dequant_stream.sv
// q_dequant_stream: 2-stage ready/valid dequantizer, per-row scale times narrow lanes, rounded and saturated
module q_dequant_stream
    import sys_defs::*;
#(
    parameter int N         = 4,
    parameter int IN_I      = 3,
    parameter int IN_F      = 4,
    parameter int S_I       = 1,
    parameter int S_F       = 14,
    parameter int OUT_I     = 7,
    parameter int OUT_F     = 8,
    parameter int ROW_BEATS = 16,
    parameter bit ROUND     = ROUNDING
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  scale_valid,
    input  logic signed [Q_WIDTH(S_I,S_F)-1:0]    scale_data,
    output logic                                  scale_ready,
    input  logic                                  in_valid,
    input  logic [N*Q_WIDTH(IN_I,IN_F)-1:0]       in_data,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic [N*Q_WIDTH(OUT_I,OUT_F)-1:0]     out_data,
    output logic                                  out_last,
    input  logic                                  out_ready
);

    localparam int IW = Q_WIDTH(IN_I, IN_F);
    localparam int SW = Q_WIDTH(S_I, S_F);
    localparam int OW = Q_WIDTH(OUT_I, OUT_F);
    localparam int PW = Q_WIDTH(IN_I + S_I + 1, IN_F + S_F);
    localparam int CW = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;

    dq_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [SW-1:0]  scale_q, scale_d;
    logic                  s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
    logic signed [PW-1:0]  s1_prod_q [N];
    logic signed [PW-1:0]  prod_d [N];
    logic [N*OW-1:0]       s2_data_q, s2_data_d;
    logic                  s1_adv, s2_adv, scale_fire, in_fire, row_end;

    assign s2_adv     = !s2_valid_q | out_ready;
    assign s1_adv     = !s1_valid_q | s2_adv;
    assign scale_fire = scale_valid & scale_ready;
    assign in_fire    = in_valid & in_ready;
    assign row_end    = cnt_q == CW'(ROW_BEATS - 1);

    // control state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= WAIT_SCALE;
        else       state_q <= state_d;
    end

    // a scale opens a row; the last beat of the row closes it on the same edge
    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_SCALE && scale_fire) state_d = ACTIVE;
        else if (state_q == ACTIVE && in_fire && row_end) state_d = WAIT_SCALE;
    end

    // handshake outputs depend only on state and pipeline room
    always_comb begin
        scale_ready = state_q == WAIT_SCALE;
        in_ready    = state_q == ACTIVE && s1_adv;
    end

    // row scale and beat counter next-state
    always_comb begin
        cnt_d   = cnt_q;
        scale_d = scale_q;
        if (scale_fire) begin
            cnt_d   = '0;
            scale_d = scale_data;
        end else if (in_fire) begin
            cnt_d = row_end ? '0 : cnt_q + CW'(1);
        end
    end

    // row scale and beat counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            scale_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            scale_q <= scale_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign prod_d[g] = PW'($signed(in_data[g*IW +: IW])) * PW'(scale_q);
        q_round_sat #(
            .IW (PW),
            .FI (IN_F + S_F),
            .OW (OW),
            .FO (OUT_F),
            .RND(ROUND)
        ) u_rs (
            .in_i (s1_prod_q[g]),
            .out_o(s2_data_d[g*OW +: OW])
        );
    end

    // stage 1 captures full-width products so each beat keeps the scale it entered with
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '{default: '0};
        end else if (s1_adv) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_prod_q <= prod_d;
                s1_last_q <= row_end;
            end
        end
    end

    // stage 2 captures aligned, saturated lanes and holds them while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_last_q <= s1_last_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;

endmodule

// File: tb/tb_q_dequant_stream.sv
// tb_q_dequant_stream: scoreboard bench over rounding, truncating and 12-bit saturating variants
module tb_q_dequant_stream;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scale_valid = 1'b0;
    logic [15:0] scale_data = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b1;

    logic        sr0, ir0, ov0, ol0, sr1, ir1, ov1, ol1, sr2, ir2, ov2, ol2;
    logic [63:0] od0, od1;
    logic [47:0] od2;

    typedef struct {
        logic [31:0] d;
        logic [15:0] s;
        bit          last;
        int          cyc;
        bit          lat;
    } ent_t;

    ent_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bcnt = 0;
    logic [15:0] cur_sc = '0;
    bit          lat_next = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    q_dequant_stream #(.ROW_BEATS(4)) u0 (
        .clock(clock), .reset(reset), .scale_valid(scale_valid), .scale_data(scale_data),
        .scale_ready(sr0), .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_last(ol0), .out_ready(out_ready));

    q_dequant_stream #(.ROW_BEATS(4), .ROUND(1'b0)) u1 (
        .clock(clock), .reset(reset), .scale_valid(scale_valid), .scale_data(scale_data),
        .scale_ready(sr1), .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_ready(out_ready));

    q_dequant_stream #(.ROW_BEATS(4), .OUT_I(3)) u2 (
        .clock(clock), .reset(reset), .scale_valid(scale_valid), .scale_data(scale_data),
        .scale_ready(sr2), .in_valid(in_valid), .in_data(in_data), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_ready(out_ready));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lane_dq(input logic [7:0] x, input logic [15:0] sc,
                                            input bit rnd, input int ow);
        longint p, r, mx, mn;
        p  = longint'($signed(x)) * longint'($signed(sc));
        r  = (p + (rnd ? 64'sd512 : 64'sd0)) >>> 10;
        mx = (longint'(1) <<< (ow - 1)) - 1;
        mn = -mx - 1;
        if (r > mx) r = mx;
        if (r < mn) r = mn;
        return 16'(r & ((longint'(1) <<< ow) - 1));
    endfunction

    function automatic logic [63:0] pack_dq(input logic [31:0] d, input logic [15:0] sc,
                                            input bit rnd, input int ow);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r = r | (64'(lane_dq(d[i*8 +: 8], sc, rnd, ow)) << (i * ow));
        return r;
    endfunction

    // scoreboard: push accepted beats, pop and compare on output handshakes
    always @(negedge clock) begin
        ent_t e;
        if (reset) begin
            sb.delete();
            bcnt   = 0;
            cur_sc = '0;
        end else begin
            if (ov0 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("data_round", od0, pack_dq(e.d, e.s, 1'b1, 16));
                    chk("data_trunc", od1, pack_dq(e.d, e.s, 1'b0, 16));
                    chk("data_sat12", 64'(od2), pack_dq(e.d, e.s, 1'b1, 12));
                    chk("out_last", 64'(ol0), 64'(e.last));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
            if (in_valid && ir0) begin
                sb.push_back('{d: in_data, s: cur_sc, last: bcnt == 3, cyc: cyc, lat: lat_next});
                lat_next = 1'b0;
                bcnt     = (bcnt == 3) ? 0 : bcnt + 1;
            end
            if (scale_valid && sr0) cur_sc = scale_data;
        end
    end

    task automatic send_scale(input logic [15:0] s);
        int t = 0;
        @(posedge clock); #1;
        scale_valid = 1'b1;
        scale_data  = s;
        do begin @(negedge clock); t++; end while (!sr0 && t < 100);
        if (!sr0) chk("scale_timeout", 64'(sr0), 64'd1);
        @(posedge clock); #1;
        scale_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin @(negedge clock); t++; end while (!ir0 && t < 100);
        if (!ir0) chk("beat_timeout", 64'(ir0), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin @(negedge clock); t++; end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_out_data", od0, 64'd0);
        chk("rst_out_last", 64'(ol0), 64'd0);
        chk("rst_in_ready", 64'(ir0), 64'd0);
        chk("rst_scale_ready", 64'(sr0), 64'd1);
        @(posedge clock); #1;
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        repeat (3) begin
            @(negedge clock);
            chk("pre_scale_in_ready", 64'(ir0), 64'd0);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;

        send_scale(16'h2000);
        lat_next = 1'b1;
        send_beat(32'h7FF00818);
        send_beat(32'h18181818);
        send_beat(32'h80017F10);
        send_beat(32'hC0E0F002);
        repeat (2) begin
            @(negedge clock);
            chk("row_end_in_ready", 64'(ir0), 64'd0);
        end
        drain();

        send_scale(16'h0200);
        send_beat(32'hFF01FF01);
        send_beat(32'h01FF01FF);
        send_beat(32'h02FE03FD);
        send_beat(32'h7F80FF01);

        send_scale(16'h6000);
        send_beat(32'h807F807F);
        send_beat(32'h7F80017F);
        send_beat(32'h40C020E0);
        send_beat(32'hFF7E8100);

        send_scale(16'hA000);
        send_beat(32'h807F8001);
        for (int i = 0; i < 3; i++) send_beat($urandom);
        drain();

        send_scale(16'h3000);
        send_beat(32'h10203040);
        out_ready = 1'b0;
        fork
            begin
                send_beat(32'h50607080);
                send_beat(32'h90A0B0C0);
                send_beat(32'hD0E0F001);
            end
            begin
                repeat (2) @(negedge clock);
                repeat (5) begin
                    @(negedge clock);
                    chk("bp_valid", 64'(ov0), 64'd1);
                    chk("bp_hold", od0, pack_dq(32'h10203040, 16'h3000, 1'b1, 16));
                    chk("bp_in_ready", 64'(ir0), 64'd0);
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        for (int r = 0; r < 3; r++) begin
            send_scale(16'($urandom));
            fork
                for (int i = 0; i < 4; i++) send_beat($urandom);
                begin
                    repeat (10) begin @(posedge clock); #1; out_ready = 1'($urandom_range(0, 1)); end
                    out_ready = 1'b1;
                end
            join
        end
        drain();

        send_scale(16'h2000);
        send_beat(32'h18181818);
        send_beat(32'h08080808);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(ov0), 64'd0);
        chk("mid_rst_scale_ready", 64'(sr0), 64'd1);
        chk("mid_rst_in_ready", 64'(ir0), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_idle", 64'(ov0), 64'd0);
        end
        send_scale(16'h4000);
        send_beat(32'h18F00801);
        send_beat(32'h7F80FF01);
        for (int i = 0; i < 2; i++) send_beat($urandom);
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/q_dequant_stream.md
# q_dequant_stream

Streaming dequantizer that widens narrow fixed-point K/V elements read from on-chip storage back into the datapath compute format. It multiplies each lane by a per-row scale, then aligns fractional bits with rounding and saturates to the output format. It sits between the K/V buffer read port and the dot-product/softmax-V datapath, and is the inverse of the requantization path that narrows values on the write side. It is a 2-stage ready/valid pipeline with a per-row scale-load FSM.

## Interface
- `N`, 4: lanes per beat.
- `IN_I`, 3: integer bits of the stored element.
- `IN_F`, 4: fractional bits of the stored element.
- `S_I`, 1: integer bits of the scale.
- `S_F`, 14: fractional bits of the scale.
- `OUT_I`, 7: integer bits of the output element.
- `OUT_F`, 8: fractional bits of the output element.
- `ROW_BEATS`, 16: data beats per row (≥1); one scale covers one row.
- `clock` in 1: sole clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `scale_valid` in 1: scale offered.
- `scale_data` in `Q_WIDTH(S_I,S_F)`: signed row scale.
- `scale_ready` out 1: scale accepted when high with `scale_valid`.
- `in_valid` in 1: data beat offered.
- `in_data` in N×`Q_WIDTH(IN_I,IN_F)`: signed lanes, lane 0 in the LSBs.
- `in_ready` out 1: beat accepted when high with `in_valid`.
- `out_valid` out 1: output beat valid.
- `out_data` out N×`Q_WIDTH(OUT_I,OUT_F)`: signed dequantized lanes.
- `out_last` out 1: marks the last beat of a row.
- `out_ready` in 1: downstream accepts.

## Operation
- FSM states:
  - WAIT_SCALE (reset state). `scale_ready`=1 and `in_ready`=0. A scale handshake latches `scale_reg`, clears `beat_cnt`, and moves to ACTIVE.
  - ACTIVE. `scale_ready`=0 and `in_ready`=`s1_adv`. Each input handshake increments `beat_cnt`. The handshake with `beat_cnt`==ROW_BEATS−1 tags the beat last, clears `beat_cnt`, and returns to WAIT_SCALE on the same edge.
- Stage 1 registers per-lane product `in_lane * scale_reg`, full width, format Q(IN_I+S_I+1, IN_F+S_F). No truncation. It also registers the last tag.
- Stage 2 handles fractional alignment from IN_F+S_F down to OUT_F:
  - When `ROUNDING` is set: add bias 2^(shift−1) in a 1-bit-extended word, then arithmetic right shift. This rounds half toward +∞. When `ROUNDING` is clear: truncating arithmetic shift.
  - Saturate to `Q_WIDTH(OUT_I,OUT_F)`: clamp to the max positive or min negative code, never wrap.
  - When OUT_F > IN_F+S_F, left-shift with zero pad, then saturate.
- Each beat carries its own scale through stage 1. A new scale loaded while earlier beats drain does not affect them.
- Backpressure:
  - `s2_adv` = !`s2_valid` | `out_ready`.
  - `s1_adv` = !`s1_valid` | `s2_adv`.
  - A stalled stage holds its data and tag unchanged.
- Simultaneous events:
  - The scale and data handshakes are mutually exclusive by state.
  - Output pop and input push in the same cycle keep full throughput.

## Timing
- Latency: in-handshake edge to `out_valid` is 2 cycles when there is no stall.
- Throughput: 1 beat/cycle within a row. Between rows there is a 1-cycle scale-load bubble on the input side only.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `in_ready`=0, `scale_ready`=1.
  - Pipeline valids=0, `beat_cnt`=0, `scale_reg`=0.
- Reset asserted mid-row drops all in-flight beats and forces WAIT_SCALE immediately. No output is produced for dropped beats.
- Output stability: `out_data` and `out_last` hold stable while `out_valid` & !`out_ready`.

## Structure
- Shared package `sys_defs`:
  - `Q_WIDTH` and `ROUNDING` (existing).
  - A `dq_state_e` enum {WAIT_SCALE, ACTIVE}.
- Sub-module `q_round_sat`: a per-lane combinational shift + round + saturate, instantiated N times in stage 2. Reuse the existing fractional-align/saturate primitives where widths permit.

## Test plan
All scenarios use default parameters with `ROUNDING`=1 unless stated.
- Basic product: scale 0x2000 (0.5), lane 0x18 (1.5) → out lane 0x0C0 (0.75) exactly 2 cycles after the handshake.
- Rounding tie: scale 0x0200 (1/32).
  - Lane 0x01 (1/16) → 0x001.
  - Lane 0xFF (−1/16) → 0x000.
  - With `ROUNDING`=0: lanes 0x01 → 0x000 and 0xFF → 0xFFFF (−1 LSB).
- Saturation, with OUT_I=3 (12-bit output):
  - Scale 0x6000 (1.5), lane 0x7F (7.9375) → 0x7FF.
  - Lane 0x80 (−8) → 0x800.
- Row framing, ROW_BEATS=4:
  - Send scale then 4 beats: `out_last` is high only on the 4th output.
  - `in_ready`=0 after the 4th beat until a new scale is accepted.
  - Beats presented before the first scale are not accepted.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-row.
  - Output is held stable.
  - `in_ready` drops once both stages are full.
  - No beat is lost or duplicated; output order matches input.
- Reset mid-row: assert `reset` with 2 beats in flight.
  - `out_valid`=0 and `scale_ready`=1 in the same cycle.
  - After deassert, a new row produces correct values.
